// File: rtl/data_memory_responder_pkg.sv
// Shared types and encodings for the MEM-stage data memory responder.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;
  localparam logic RW_LOAD   = 1'b0;
  localparam logic RW_STORE  = 1'b1;

  localparam int WAIT_STATES_MAX = 15;

  // Lane 0 is the most significant byte of the big-endian word.
  function automatic logic [3:0] byte_lane_en(input logic is_byte, input logic [1:0] offset);
    if (is_byte) begin
      byte_lane_en = 4'b0001 << offset;
    end else begin
      byte_lane_en = 4'b1111;
    end
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-addressable big-endian storage: lane-enabled synchronous write, combinational word/byte read.
// The init_* port is a preload path for test images and is tied off in the responder.
module data_mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rd_word,
  output logic [7:0]        rd_byte,
  input  logic              init_en,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [7:0]        init_data
);

  logic [7:0] mem [2**ADDR_W];

  // Storage write: preload takes priority, otherwise enabled lanes of the aligned word.
  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_addr] <= init_data;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[{addr[ADDR_W-1:2], 2'(i)}] <= wdata[8*(3-i) +: 8];
        end
      end
    end
  end

  assign rd_word = {mem[{addr[ADDR_W-1:2], 2'b00}], mem[{addr[ADDR_W-1:2], 2'b01}],
                    mem[{addr[ADDR_W-1:2], 2'b10}], mem[{addr[ADDR_W-1:2], 2'b11}]};
  assign rd_byte = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage responder: captures a load/store, waits WAIT_STATES cycles, accesses the
// big-endian array and pulses done; stall holds the EX/MEM register meanwhile.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              E,
  input  logic              RW,
  input  logic              size,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              done,
  output logic              stall,
  output logic              misalign
);

  localparam int WS_EFF = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       di_q, di_d;
  logic              rw_q, rw_d;
  logic              size_q, size_d;
  logic [31:0]       do_q, do_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic [3:0]        mem_we_s;
  logic [31:0]       mem_wdata_s;
  logic [31:0]       rd_word_s;
  logic [7:0]        rd_byte_s;

  // Next-state, capture, array-control and response logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    di_d        = di_q;
    rw_d        = rw_q;
    size_d      = size_q;
    do_d        = do_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    mem_we_s    = 4'b0000;
    mem_wdata_s = di_q;
    case (state_q)
      ST_IDLE: begin
        if (E) begin
          a_d     = A;
          di_d    = DI;
          rw_d    = RW;
          size_d  = size;
          cnt_d   = 4'(WS_EFF);
          state_d = (WS_EFF > 0) ? ST_BUSY : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_ACCESS: begin
        state_d    = ST_RESP;
        done_d     = 1'b1;
        misalign_d = (size_q == SIZE_WORD) && (a_q[1:0] != 2'b00);
        if (rw_q == RW_LOAD) begin
          do_d = (size_q == SIZE_BYTE) ? {24'h000000, rd_byte_s} : rd_word_s;
        end else begin
          // A byte store replicates DI[7:0] so any single enabled lane picks it up.
          mem_we_s    = byte_lane_en(size_q == SIZE_BYTE, a_q[1:0]);
          mem_wdata_s = (size_q == SIZE_BYTE) ? {4{di_q[7:0]}} : di_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight request.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      a_q        <= {ADDR_W{1'b0}};
      di_q       <= 32'h0000_0000;
      rw_q       <= 1'b0;
      size_q     <= 1'b0;
      do_q       <= 32'h0000_0000;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      di_q       <= di_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      do_q       <= do_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  data_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (Clk),
    .we        (mem_we_s),
    .addr      (a_q),
    .wdata     (mem_wdata_s),
    .rd_word   (rd_word_s),
    .rd_byte   (rd_byte_s),
    .init_en   (1'b0),
    .init_addr ({ADDR_W{1'b0}}),
    .init_data (8'h00)
  );

  assign DO       = do_q;
  assign done     = done_q;
  assign misalign = misalign_q;
  assign stall    = E & ~done_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against a latency/byte-array model.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rw_i = 1'b0;
  logic        sz_i = 1'b0;
  logic [7:0]  a_i = 8'h00;
  logic [31:0] di_i = 32'h0;
  logic        e_i      [2];
  logic [31:0] dout     [2];
  logic        done_o   [2];
  logic        stall_o  [2];
  logic        mis_o    [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit en_cmp   = 1'b0;

  int          ws_of    [2] = '{2, 0};
  logic [7:0]  mmem     [2][256];
  int          rem      [2];
  logic        cap_rw   [2];
  logic        cap_sz   [2];
  logic [7:0]  cap_a    [2];
  logic [31:0] cap_di   [2];
  logic [31:0] exp_do   [2];
  logic        exp_done [2];
  logic        exp_mis  [2];

  always #5 clk = ~clk;

  data_memory_responder #(.WAIT_STATES(2), .ADDR_W(8)) dut_ws2 (
    .Clk(clk), .Clr(clr), .E(e_i[0]), .RW(rw_i), .size(sz_i), .A(a_i), .DI(di_i),
    .DO(dout[0]), .done(done_o[0]), .stall(stall_o[0]), .misalign(mis_o[0])
  );

  data_memory_responder #(.WAIT_STATES(0), .ADDR_W(8)) dut_ws0 (
    .Clk(clk), .Clr(clr), .E(e_i[1]), .RW(rw_i), .size(sz_i), .A(a_i), .DI(di_i),
    .DO(dout[1]), .done(done_o[1]), .stall(stall_o[1]), .misalign(mis_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request accepted at edge 0 completes at edge WS+1, idles at WS+2.
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 0; k < 2; k++) begin
        rem[k] <= 0; exp_done[k] <= 1'b0; exp_mis[k] <= 1'b0; exp_do[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_done[k] <= 1'b0;
        exp_mis[k]  <= 1'b0;
        if (rem[k] == 0) begin
          if (e_i[k]) begin
            cap_rw[k] <= rw_i; cap_sz[k] <= sz_i; cap_a[k] <= a_i; cap_di[k] <= di_i;
            rem[k] <= ws_of[k] + 2;
          end
        end else begin
          rem[k] <= rem[k] - 1;
          if (rem[k] == 2) begin
            exp_done[k] <= 1'b1;
            exp_mis[k]  <= !cap_sz[k] && (cap_a[k][1:0] != 2'b00);
            if (cap_rw[k]) begin
              if (cap_sz[k]) begin
                mmem[k][cap_a[k]] <= cap_di[k][7:0];
              end else begin
                mmem[k][(cap_a[k] & 8'hFC)]         <= cap_di[k][31:24];
                mmem[k][(cap_a[k] & 8'hFC) + 8'd1]  <= cap_di[k][23:16];
                mmem[k][(cap_a[k] & 8'hFC) + 8'd2]  <= cap_di[k][15:8];
                mmem[k][(cap_a[k] & 8'hFC) + 8'd3]  <= cap_di[k][7:0];
              end
            end else if (cap_sz[k]) begin
              exp_do[k] <= {24'h0, mmem[k][cap_a[k]]};
            end else begin
              exp_do[k] <= {mmem[k][(cap_a[k] & 8'hFC)], mmem[k][(cap_a[k] & 8'hFC) + 8'd1],
                            mmem[k][(cap_a[k] & 8'hFC) + 8'd2], mmem[k][(cap_a[k] & 8'hFC) + 8'd3]};
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of both responders against the model.
  always @(posedge clk) begin
    #1;
    if (en_cmp) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("done[%0d]", k), {31'h0, done_o[k]}, {31'h0, exp_done[k]});
        chk($sformatf("misalign[%0d]", k), {31'h0, mis_o[k]}, {31'h0, exp_mis[k]});
        chk($sformatf("stall[%0d]", k), {31'h0, stall_o[k]}, {31'h0, e_i[k] & ~exp_done[k]});
        chk($sformatf("DO[%0d]", k), dout[k], exp_do[k]);
      end
    end
  end

  task automatic req(input int k, input logic rw_v, input logic sz_v, input logic [7:0] av,
                     input logic [31:0] dv, output int lat);
    @(negedge clk);
    e_i[k] = 1'b1; rw_i = rw_v; sz_i = sz_v; a_i = av; di_i = dv;
    lat = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done_o[k]) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) chk("req_timeout", 32'd0, 32'd1);
    e_i[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int gap;
    int ndone;
    e_i[0] = 1'b0; e_i[1] = 1'b0;
    #2 clr = 1'b0;
    en_cmp = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_DO", dout[0], 32'h0);
    chk("rst_done", {31'h0, done_o[0]}, 32'h0);
    clr = 1'b1;

    // Preload images through the store path.
    req(0, 1'b1, 1'b0, 8'h10, 32'h0000_0000, lat);
    req(1, 1'b1, 1'b0, 8'hFC, 32'hCAFE_F00D, lat);

    // Abort a word store mid-BUSY with reset.
    @(negedge clk);
    e_i[0] = 1'b1; rw_i = 1'b1; sz_i = 1'b0; a_i = 8'h10; di_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    clr = 1'b0; e_i[0] = 1'b0;
    @(negedge clk);
    chk("abort_DO", dout[0], 32'h0);
    chk("abort_done", {31'h0, done_o[0]}, 32'h0);
    clr = 1'b1;
    req(0, 1'b0, 1'b0, 8'h10, 32'h0, lat);
    chk("abort_load", dout[0], 32'h0000_0000);

    // Word store/load and byte load at 2 wait states.
    req(0, 1'b1, 1'b0, 8'h20, 32'h1234_5678, lat);
    chk("store_lat", lat, 32'd4);
    req(0, 1'b0, 1'b0, 8'h20, 32'h0, lat);
    chk("load_w20", dout[0], 32'h1234_5678);
    chk("load_lat", lat, 32'd4);
    req(0, 1'b0, 1'b1, 8'h21, 32'h0, lat);
    chk("load_b21", dout[0], 32'h0000_0034);

    // Byte store into a word, then aligned and misaligned word loads.
    req(0, 1'b1, 1'b0, 8'h40, 32'hAABB_CCDD, lat);
    req(0, 1'b1, 1'b1, 8'h42, 32'hFFFF_FF11, lat);
    req(0, 1'b0, 1'b0, 8'h40, 32'h0, lat);
    chk("load_w40", dout[0], 32'hAABB_11DD);
    chk("aligned_mis", {31'h0, mis_o[0]}, 32'h0);
    req(0, 1'b0, 1'b0, 8'h43, 32'h0, lat);
    chk("load_w43", dout[0], 32'hAABB_11DD);
    chk("misalign_w43", {31'h0, mis_o[0]}, 32'h1);

    // E held high across two requests: second accepted only after the idle bubble.
    @(negedge clk);
    e_i[0] = 1'b1; rw_i = 1'b0; sz_i = 1'b0; a_i = 8'h20;
    lat = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done_o[0]) begin lat = c; break; end
    end
    chk("hs_first_lat", lat, 32'd4);
    chk("hs_first_DO", dout[0], 32'h1234_5678);
    chk("hs_stall_resp", {31'h0, stall_o[0]}, 32'h0);
    a_i = 8'h40;
    gap = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done_o[0]) begin gap = c; break; end
    end
    chk("hs_gap", gap, 32'd5);
    chk("hs_second_DO", dout[0], 32'hAABB_11DD);
    e_i[0] = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    chk("hs_no_extra_done", ndone, 32'd0);

    // Zero wait states: top-of-memory word, no wrap.
    req(1, 1'b0, 1'b0, 8'hFC, 32'h0, lat);
    chk("ws0_load_FC", dout[1], 32'hCAFE_F00D);
    chk("ws0_lat", lat, 32'd2);
    req(1, 1'b0, 1'b1, 8'hFF, 32'h0, lat);
    chk("ws0_load_bFF", dout[1], 32'h0000_000D);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
